// File: rtl/kuz_key_expand_if.sv
// Key-expansion request and key_storage write bus for kuz_key_expand.
// master: the key generator (drives ks_* and status); slave: requester / storage side.
interface kuz_key_expand_if;
    logic         start;
    logic [255:0] key_in;
    logic [127:0] ks_data;
    logic [3:0]   ks_addr;
    logic         ks_we;
    logic         busy;
    logic         done;

    modport master (
        input  start, key_in,
        output ks_data, ks_addr, ks_we, busy, done
    );

    modport slave (
        output start, key_in,
        input  ks_data, ks_addr, ks_we, busy, done
    );
endinterface

// File: rtl/kuz_key_expand.sv
// Kuznechik round-key generator: one Feistel round at a time, L as 16 serial R steps.
// Optional KUZ_KEXP_CONST_ROM_EN: take C_i from an elaborated 32x128 ROM instead of the CONST phase.
module kuz_key_expand #(
    parameter logic [3:0] BASE_ADDR = 4'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    kuz_key_expand_if.master kif
);

    typedef enum logic [3:0] {
        IDLE, WR0, WR1, CONST, XS, LIN, FEIST, WRA, WRB, DONE
    } state_t;

    // l coefficients packed so that byte k multiplies a_k
    localparam logic [127:0] LCOEF = {
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    localparam logic [2047:0] PI = {
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [127:0] r_step(input logic [127:0] a);
        logic [7:0] l;
        l = 8'h00;
        for (int k = 0; k < 16; k++) l = l ^ gf_mul(a[8*k +: 8], LCOEF[8*k +: 8]);
        return {l, a[127:8]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] a);
        logic [127:0] s;
        for (int k = 0; k < 16; k++) s[8*k +: 8] = PI[8*(255 - int'(a[8*k +: 8])) +: 8];
        return s;
    endfunction

    state_t       state;
    logic [127:0] a1;
    logic [127:0] a0;
    logic [127:0] t;
    logic [5:0]   i;
    logic [3:0]   step;
    logic [127:0] cval;

`ifdef KUZ_KEXP_CONST_ROM_EN
    localparam state_t ROUND_ENTRY = XS;

    function automatic logic [127:0] round_const(input logic [5:0] n);
        logic [127:0] c;
        c = {122'd0, n};
        for (int k = 0; k < 16; k++) c = r_step(c);
        return c;
    endfunction

    logic [127:0] crom [32];
    for (genvar g = 0; g < 32; g++) begin : g_crom
        localparam logic [127:0] C = round_const(6'(g + 1));
        assign crom[g] = C;
    end

    // i runs 1..32; the 5-bit wrap maps 32 onto entry 31
    logic [4:0] crom_idx;
    assign crom_idx = i[4:0] - 5'd1;
    assign cval     = crom[crom_idx];
`else
    localparam state_t ROUND_ENTRY = CONST;
    assign cval = t;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a1          <= '0;
            a0          <= '0;
            t           <= '0;
            i           <= '0;
            step        <= '0;
            kif.ks_we   <= 1'b0;
            kif.ks_data <= '0;
            kif.ks_addr <= '0;
            kif.busy    <= 1'b0;
            kif.done    <= 1'b0;
        end else begin
            kif.ks_we <= 1'b0;
            kif.done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (kif.start) begin
                        a1          <= kif.key_in[255:128];
                        a0          <= kif.key_in[127:0];
                        i           <= 6'd1;
                        kif.ks_we   <= 1'b1;
                        kif.ks_addr <= BASE_ADDR;
                        kif.ks_data <= kif.key_in[255:128];
                        kif.busy    <= 1'b1;
                        state       <= WR0;
                    end
                end
                WR0: begin
                    kif.ks_we   <= 1'b1;
                    kif.ks_addr <= kif.ks_addr + 4'd1;
                    kif.ks_data <= a0;
                    state       <= WR1;
                end
                WR1: begin
                    t     <= {122'd0, i};
                    step  <= '0;
                    state <= ROUND_ENTRY;
                end
                CONST: begin
                    t    <= r_step(t);
                    step <= step + 4'd1;
                    if (step == 4'd15) state <= XS;
                end
                XS: begin
                    t     <= sub_bytes(a1 ^ cval);
                    step  <= '0;
                    state <= LIN;
                end
                LIN: begin
                    t    <= r_step(t);
                    step <= step + 4'd1;
                    if (step == 4'd15) state <= FEIST;
                end
                FEIST: begin
                    a1 <= t ^ a0;
                    a0 <= a1;
                    i  <= i + 6'd1;
                    // every 8th round emits a key pair at BASE_ADDR + 2*(i/8)
                    if (i[2:0] == 3'd0) begin
                        kif.ks_we   <= 1'b1;
                        kif.ks_addr <= BASE_ADDR + {i[5:3], 1'b0};
                        kif.ks_data <= t ^ a0;
                        state       <= WRA;
                    end else begin
                        t     <= {122'd0, i + 6'd1};
                        step  <= '0;
                        state <= ROUND_ENTRY;
                    end
                end
                WRA: begin
                    kif.ks_we   <= 1'b1;
                    kif.ks_addr <= kif.ks_addr + 4'd1;
                    kif.ks_data <= a0;
                    state       <= WRB;
                end
                WRB: begin
                    if (i == 6'd33) begin
                        kif.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        t     <= {122'd0, i};
                        step  <= '0;
                        state <= ROUND_ENTRY;
                    end
                end
                DONE: begin
                    kif.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kuz_key_expand.sv
// Randomized bench for kuz_key_expand: a byte-array key-schedule model predicts every
// cycle of ks_we/ks_addr/ks_data/busy/done for a BASE_ADDR=0 and a BASE_ADDR=8 instance.
module tb_kuz_key_expand;

`ifdef KUZ_KEXP_CONST_ROM_EN
    localparam int RC = 18;
`else
    localparam int RC = 34;
`endif
    localparam int DC = 2 + 32 * RC + 8 + 1;

    localparam logic [255:0] K_TV =
        256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
    localparam logic [127:0] K1_TV  = 128'h8899aabbccddeeff0011223344556677;
    localparam logic [127:0] K2_TV  = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] K3_TV  = 128'hdb31485315694343228d6aef8cc78c44;
    localparam logic [127:0] K4_TV  = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
    localparam logic [127:0] K10_TV = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
    localparam logic [127:0] C1_TV  = 128'h6ea276726c487ab85d27bd10dd849401;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [255:0] key_in = '0;

    always #5 clk = ~clk;

    kuz_key_expand_if kif0 ();
    kuz_key_expand_if kif8 ();
    assign kif0.start  = start;
    assign kif0.key_in = key_in;
    assign kif8.start  = start;
    assign kif8.key_in = key_in;

    kuz_key_expand #(.BASE_ADDR(4'd0)) dut0 (.clk(clk), .rst_n(rst_n), .kif(kif0));
    kuz_key_expand #(.BASE_ADDR(4'd8)) dut8 (.clk(clk), .rst_n(rst_n), .kif(kif8));

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] pi_tab [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // lc[k] multiplies a_k
    logic [7:0] lc [16] = '{8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
                            8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int acc;
        int x;
        acc = 0;
        x = int'(a);
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ x;
            x = x << 1;
            if ((x & 32'h100) != 0) x = x ^ 32'h1C3;
        end
        return acc[7:0];
    endfunction

    function automatic logic [127:0] big_l(input logic [127:0] v);
        logic [7:0]   b [16];
        logic [7:0]   s;
        logic [127:0] r;
        for (int k = 0; k < 16; k++) b[k] = v[8*k +: 8];
        for (int n = 0; n < 16; n++) begin
            s = 8'h00;
            for (int k = 0; k < 16; k++) s = s ^ gmul(b[k], lc[k]);
            for (int k = 0; k < 15; k++) b[k] = b[k+1];
            b[15] = s;
        end
        for (int k = 0; k < 16; k++) r[8*k +: 8] = b[k];
        return r;
    endfunction

    // All ten round keys, K(n+1) in bits [128n +: 128]
    function automatic logic [1279:0] sched(input logic [255:0] key);
        logic [1279:0] ks;
        logic [127:0]  x1, x0, x, nx;
        ks = '0;
        x1 = key[255:128];
        x0 = key[127:0];
        ks[0 +: 128]   = x1;
        ks[128 +: 128] = x0;
        for (int n = 1; n <= 32; n++) begin
            x = x1 ^ big_l(128'(n));
            for (int k = 0; k < 16; k++) x[8*k +: 8] = pi_tab[x[8*k +: 8]];
            nx = big_l(x) ^ x0;
            x0 = x1;
            x1 = nx;
            if (n % 8 == 0) begin
                ks[256*(n/8) +: 128]       = x1;
                ks[256*(n/8) + 128 +: 128] = x0;
            end
        end
        return ks;
    endfunction

    // Key index written in cycle c of a run (cycle 1 = first after accepting start), or -1
    function automatic int wr_index(input int c);
        int w;
        if (c == 1) return 0;
        if (c == 2) return 1;
        for (int j = 1; j <= 4; j++) begin
            w = 2 + 8 * j * RC + 2 * (j - 1) + 1;
            if (c == w)     return 2 * j;
            if (c == w + 1) return 2 * j + 1;
        end
        return -1;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0]  ram0 [16];
    logic [127:0]  ram8 [16];
    logic [1279:0] keys = '0;
    int            mcyc = 0;
    int            wcnt0 = 0, wcnt8 = 0, dcnt0 = 0, dcnt8 = 0;

    initial begin
        int           widx;
        logic [3:0]   l_ad0, l_ad8;
        logic [127:0] l_dat;
        l_ad0 = '0;
        l_ad8 = '0;
        l_dat = '0;
        for (int a = 0; a < 16; a++) begin
            ram0[a] = '0;
            ram8[a] = '0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mcyc  = 0;
                l_ad0 = '0;
                l_ad8 = '0;
                l_dat = '0;
            end
            widx = wr_index(mcyc);
            if (widx >= 0) begin
                l_dat = keys[128*widx +: 128];
                l_ad0 = 4'(widx);
                l_ad8 = 4'(widx + 8);
            end
            chk("we0", kif0.ks_we, widx >= 0);
            chk("addr0", kif0.ks_addr, l_ad0);
            chk("data0", kif0.ks_data, l_dat);
            chk("busy0", kif0.busy, mcyc != 0);
            chk("done0", kif0.done, mcyc == DC);
            chk("we8", kif8.ks_we, widx >= 0);
            chk("addr8", kif8.ks_addr, l_ad8);
            chk("data8", kif8.ks_data, l_dat);
            chk("busy8", kif8.busy, mcyc != 0);
            chk("done8", kif8.done, mcyc == DC);
            if (kif0.ks_we === 1'b1) begin ram0[kif0.ks_addr] = kif0.ks_data; wcnt0++; end
            if (kif8.ks_we === 1'b1) begin ram8[kif8.ks_addr] = kif8.ks_data; wcnt8++; end
            if (kif0.done === 1'b1) dcnt0++;
            if (kif8.done === 1'b1) dcnt8++;
            if (rst_n) begin
                if (mcyc == 0) begin
                    if (start) begin
                        keys = sched(key_in);
                        mcyc = 1;
                    end
                end else if (mcyc == DC) begin
                    mcyc = 0;
                end else begin
                    mcyc++;
                end
            end
        end
    end

    task automatic pulse_start(input logic [255:0] k);
        @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = k;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = rand256();
    endtask

    // Returns in the DONE cycle; throws ignored start pulses at the busy DUT meanwhile
    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < DC + 200 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (kif0.done === 1'b1) begin
                seen  = 1'b1;
                start = 1'b0;
            end else begin
                start  = ($urandom_range(0, 63) == 0);
                key_in = rand256();
            end
        end
        if (!seen) chk("done_timeout", 1'b0, 1'b1);
    endtask

    // Holds start through the DONE cycle, where it must be ignored
    task automatic start_in_done();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_tv_keys(input string tag);
        chk({tag, "_ram0_0"}, ram0[0], K1_TV);
        chk({tag, "_ram0_1"}, ram0[1], K2_TV);
        chk({tag, "_ram0_2"}, ram0[2], K3_TV);
        chk({tag, "_ram0_3"}, ram0[3], K4_TV);
        chk({tag, "_ram0_9"}, ram0[9], K10_TV);
        chk({tag, "_ram8_8"}, ram8[8], K1_TV);
        chk({tag, "_ram8_11"}, ram8[11], K4_TV);
        chk({tag, "_ram8_1"}, ram8[1], K10_TV);
    endtask

    initial begin
        logic [1279:0] ks;
        logic [255:0]  kr;
        int            w0, d0;

        ks = sched(K_TV);
        chk("model_C1", big_l(128'd1), C1_TV);
        chk("model_K1", ks[0 +: 128], K1_TV);
        chk("model_K2", ks[128 +: 128], K2_TV);
        chk("model_K3", ks[256 +: 128], K3_TV);
        chk("model_K4", ks[384 +: 128], K4_TV);
        chk("model_K10", ks[1152 +: 128], K10_TV);

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Test vector run with a stray start (key 0) at cycle 500
        w0 = wcnt0;
        d0 = dcnt0;
        pulse_start(K_TV);
        repeat (499) @(posedge clk);
        #1;
        start  = 1'b1;
        key_in = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        start_in_done();
        check_tv_keys("tv");
        chk("tv_writes", 128'(wcnt0 - w0), 128'd10);
        chk("tv_dones", 128'(dcnt0 - d0), 128'd1);
        for (int a = 2; a < 8; a++) chk($sformatf("ram8_untouched_%0d", a), ram8[a], 128'd0);

        // Abort at cycle 300, then rerun the test vector
        pulse_start(rand256());
        repeat (299) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        pulse_start(K_TV);
        wait_done();
        start_in_done();
        check_tv_keys("rerun");

        // Back-to-back random keys, each started in the first IDLE cycle after done
        w0 = wcnt0;
        d0 = dcnt0;
        kr = '0;
        for (int r = 0; r < 4; r++) begin
            kr = rand256();
            pulse_start(kr);
            wait_done();
        end
        @(posedge clk);
        #1;
        ks = sched(kr);
        for (int n = 0; n < 10; n++) begin
            chk($sformatf("b2b_ram0_%0d", n), ram0[n], ks[128*n +: 128]);
            chk($sformatf("b2b_ram8_%0d", (n + 8) % 16), ram8[(n + 8) % 16], ks[128*n +: 128]);
        end
        chk("b2b_writes", 128'(wcnt0 - w0), 128'd40);
        chk("b2b_dones", 128'(dcnt0 - d0), 128'd4);
        for (int a = 2; a < 8; a++) chk($sformatf("ram8_clean_%0d", a), ram8[a], 128'd0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
